// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, output bundle
// and helpers. Also imported by the debug register block to decode the state field.
package pll_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUNNING   = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    typedef struct packed {
        logic pll_rst;
        logic out_rst;
        logic ready;
        logic fault;
    } pll_outs_t;

    localparam pll_outs_t OUTS_RESET = '{pll_rst: 1'b1, out_rst: 1'b1, ready: 1'b0, fault: 1'b0};

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Output levels that hold while the sequencer sits in state s.
    function automatic pll_outs_t decode_outputs(input pll_state_e s);
        pll_outs_t o;
        o = OUTS_RESET;
        case (s)
            ST_WAIT_LOCK, ST_STABILIZE: o.pll_rst = 1'b0;
            ST_RUNNING: begin
                o.pll_rst = 1'b0;
                o.out_rst = 1'b0;
                o.ready   = 1'b1;
            end
            ST_FAULT: o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer that brings a single asynchronous bit into the clk domain.
// The output lags the input by STAGES clock edges.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        // NOTE: synchronizer flops are reset so downstream logic sees a clean 0 after rst.
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings an external PLL out of reset, waits for a stable lock, then releases the
// PLL-domain logic; retries on lock timeout and parks in FAULT after MAX_RETRIES.
module pll_reset_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               restart,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               out_rst,
    output logic               ready,
    output logic               fault,
    output logic [7:0]         lol_count,
    output logic [STATE_W-1:0] state
);

    localparam int CNT_W = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) + 1;
    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_ONE      = RET_W'(1);
    localparam logic [RET_W-1:0] RET_LIMIT    = RET_W'(MAX_RETRIES);

    logic             lk;
    pll_state_e       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [RET_W-1:0] retries_q, retries_d;
    logic [RET_W-1:0] retries_inc;
    logic [7:0]       lol_q,     lol_d;
    pll_outs_t        outs_q,    outs_d;

    bit_sync #(
        .STAGES (2)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lk)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= '0;
            retries_q <= '0;
            lol_q     <= '0;
            outs_q    <= OUTS_RESET;
        end else begin
            // NOTE: non-blocking so every register samples its peers' pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            lol_q     <= lol_d;
            outs_q    <= outs_d;
        end
    end

    assign retries_inc = retries_q + RET_ONE;

    always_comb begin
        // NOTE: hold values assigned first so no branch leaves a signal unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        lol_d     = lol_q;

        if (restart) begin
            state_d   = ST_RESET_PLL;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q >= PULSE_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lk) begin
                        // The detecting cycle is the first of the stable-lock run.
                        cnt_d   = CNT_ONE;
                        state_d = (LOCK_STABLE_CYCLES <= 1) ? ST_RUNNING : ST_STABILIZE;
                    end else if (cnt_q >= TIMEOUT_LAST) begin
                        cnt_d     = '0;
                        retries_d = retries_inc;
                        state_d   = (retries_inc == RET_LIMIT) ? ST_FAULT : ST_RESET_PLL;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STABILIZE: begin
                    if (!lk) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q >= STABLE_LAST) begin
                        state_d = ST_RUNNING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUNNING: begin
                    if (!lk) begin
                        state_d   = ST_RESET_PLL;
                        cnt_d     = '0;
                        retries_d = '0;
                        if (lol_q != 8'hFF) begin
                            lol_d = lol_q + 8'd1;
                        end
                    end
                end
                ST_FAULT: ;
                default: begin
                    state_d   = ST_RESET_PLL;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as state.
    always_comb begin
        outs_d = decode_outputs(state_d);
    end

    assign pll_rst   = outs_q.pll_rst;
    assign out_rst   = outs_q.out_rst;
    assign ready     = outs_q.ready;
    assign fault     = outs_q.fault;
    assign lol_count = lol_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios followed by randomized lock
// behaviour, all checked every cycle against a cycle-count reference model.
module tb_pll_reset_sequencer;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int ST = 8;
    localparam int MR = 2;
    localparam int SYNC_LAG = 2;

    localparam int P_RESET = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STAB  = 2;
    localparam int P_RUN   = 3;
    localparam int P_FAULT = 4;

    localparam int SEL_PLL_RST = 0;
    localparam int SEL_OUT_RST = 1;
    localparam int SEL_READY   = 2;
    localparam int SEL_FAULT   = 3;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       restart    = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       out_rst;
    logic       ready;
    logic       fault;
    logic [7:0] lol_count;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    // Reference model: phase, cycles spent in phase, consecutive lock cycles,
    // failed attempts, lock-loss count, and a delay line standing in for the synchronizer.
    int m_phase = P_RESET;
    int m_n     = 0;
    int m_good  = 0;
    int m_att   = 0;
    int m_lol   = 0;
    bit hist[$] = '{1'b0, 1'b0};

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (ST),
        .MAX_RETRIES         (MR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .restart    (restart),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .out_rst    (out_rst),
        .ready      (ready),
        .fault      (fault),
        .lol_count  (lol_count),
        .state      (state)
    );

    always #5 refclk = ~refclk;

    task automatic model_step();
        bit lk;
        if (rst) begin
            m_phase = P_RESET;
            m_n     = 0;
            m_good  = 0;
            m_att   = 0;
            m_lol   = 0;
            hist.delete();
            hist.push_back(1'b0);
            hist.push_back(1'b0);
            return;
        end
        lk = hist.pop_front();
        hist.push_back(pll_locked);
        if (restart) begin
            m_phase = P_RESET;
            m_n     = 0;
            m_att   = 0;
        end else begin
            case (m_phase)
                P_RESET: begin
                    m_n++;
                    if (m_n == RP) begin
                        m_phase = P_WAIT;
                        m_n     = 0;
                    end
                end
                P_WAIT: begin
                    if (lk) begin
                        m_good  = 1;
                        m_phase = (m_good == ST) ? P_RUN : P_STAB;
                    end else begin
                        m_n++;
                        if (m_n == TO) begin
                            m_att++;
                            m_n     = 0;
                            m_phase = (m_att == MR) ? P_FAULT : P_RESET;
                        end
                    end
                end
                P_STAB: begin
                    if (!lk) begin
                        m_phase = P_WAIT;
                        m_n     = 0;
                    end else begin
                        m_good++;
                        if (m_good == ST) m_phase = P_RUN;
                    end
                end
                P_RUN: begin
                    if (!lk) begin
                        if (m_lol < 255) m_lol++;
                        m_att   = 0;
                        m_n     = 0;
                        m_phase = P_RESET;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock: advance the model at the edge, compare everything on the falling edge.
    task automatic tick();
        logic [14:0] obs;
        logic [14:0] exp;
        @(posedge refclk);
        model_step();
        @(negedge refclk);
        obs = {state, pll_rst, out_rst, ready, fault, lol_count};
        exp = {3'(m_phase),
               (m_phase == P_RESET) || (m_phase == P_FAULT),
               (m_phase != P_RUN),
               (m_phase == P_RUN),
               (m_phase == P_FAULT),
               8'(m_lol)};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL cycle_model: dut %h model %h at %0t", obs, exp, $time);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            SEL_PLL_RST: return pll_rst;
            SEL_OUT_RST: return out_rst;
            SEL_READY:   return ready;
            default:     return fault;
        endcase
    endfunction

    task automatic wait_until(input string tag, input int sel, input logic val,
                              input int limit, output int n);
        n = 0;
        while (probe(sel) !== val && n < limit) begin
            tick();
            n++;
        end
        total++;
        assert (probe(sel) === val) else begin
            bad++;
            $error("FAIL %s: got %b expected %b after %0d cycles", tag, probe(sel), val, n);
        end
    endtask

    task automatic wait_state(input string tag, input int s, input int limit, output int n);
        n = 0;
        while (state !== 3'(s) && n < limit) begin
            tick();
            n++;
        end
        total++;
        assert (state === 3'(s)) else begin
            bad++;
            $error("FAIL %s: got state %0d expected %0d after %0d cycles", tag, state, s, n);
        end
    endtask

    initial begin
        int n;
        int hold;
        bit saw_wait;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        expect_val("rst_state",   state,     P_RESET);
        expect_val("rst_pll_rst", pll_rst,   1);
        expect_val("rst_out_rst", out_rst,   1);
        expect_val("rst_ready",   ready,     0);
        expect_val("rst_fault",   fault,     0);
        expect_val("rst_lol",     lol_count, 0);

        // Nominal bring-up
        rst = 1'b0;
        wait_until("pll_rst_fall", SEL_PLL_RST, 1'b0, 50, n);
        expect_val("pll_rst_pulse", n, RP);
        repeat (3) tick();
        pll_locked = 1'b1;
        wait_until("ready_rise", SEL_READY, 1'b1, 100, n);
        expect_val("lock_to_ready", n, SYNC_LAG + ST);
        expect_val("run_out_rst", out_rst, 0);

        // One-cycle lock glitch during STABILIZE
        pll_locked = 1'b0;
        restart    = 1'b1;
        tick();
        restart = 1'b0;
        expect_val("restart_state", state, P_RESET);
        expect_val("restart_lol", lol_count, 0);
        wait_state("glitch_to_wait", P_WAIT, 20, n);
        pll_locked = 1'b1;
        wait_state("glitch_to_stab", P_STAB, 10, n);
        tick();
        tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        n = 0;
        saw_wait = 1'b0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (state === 3'(P_WAIT)) saw_wait = 1'b1;
        end
        expect_val("glitch_back_to_wait", saw_wait, 1);
        expect_val("glitch_ready_lat", n, SYNC_LAG + ST);

        // Loss of lock in RUNNING: synchronizer lag plus the registered decision
        pll_locked = 1'b0;
        wait_until("lol_out_rst", SEL_OUT_RST, 1'b1, 20, n);
        expect_val("lol_latency", n, SYNC_LAG + 1);
        expect_val("lol_ready", ready, 0);
        expect_val("lol_count_1", lol_count, 1);

        // restart coincides with the lk drop seen in RUNNING
        pll_locked = 1'b1;
        wait_until("prio_ready", SEL_READY, 1'b1, 100, n);
        pll_locked = 1'b0;
        tick();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        expect_val("prio_state", state, P_RESET);
        expect_val("prio_lol", lol_count, 1);

        // Saturation of lol_count
        pll_locked = 1'b1;
        for (int i = 0; i < 258; i++) begin
            wait_until("sat_ready", SEL_READY, 1'b1, 100, n);
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            wait_until("sat_drop", SEL_OUT_RST, 1'b1, 10, n);
        end
        expect_val("lol_saturated", lol_count, 255);

        // rst during STABILIZE clears everything including lol_count
        wait_state("rst_in_stab", P_STAB, 40, n);
        tick();
        rst = 1'b1;
        tick();
        expect_val("mid_rst_state",   state,     P_RESET);
        expect_val("mid_rst_pll_rst", pll_rst,   1);
        expect_val("mid_rst_out_rst", out_rst,   1);
        expect_val("mid_rst_ready",   ready,     0);
        expect_val("mid_rst_fault",   fault,     0);
        expect_val("mid_rst_lol",     lol_count, 0);
        rst = 1'b0;
        wait_until("post_rst_pulse", SEL_PLL_RST, 1'b0, 50, n);
        expect_val("post_rst_pulse_len", n, RP);

        // Lock never arrives: MR attempts then FAULT
        pll_locked = 1'b0;
        repeat (3) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        wait_until("fault_rise", SEL_FAULT, 1'b1, 200, n);
        expect_val("timeout_total", n, MR * (RP + TO));
        expect_val("fault_pll_rst", pll_rst, 1);
        expect_val("fault_state", state, P_FAULT);
        repeat (10) tick();
        expect_val("fault_sticky", fault, 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        expect_val("fault_restart_state", state, P_RESET);
        expect_val("fault_restart_fault", fault, 0);

        // Randomized lock behaviour with sporadic restart and rst
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                hold = int'($urandom_range(1, 60));
            end
            hold--;
            restart = ($urandom_range(0, 63) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
        end
        restart = 1'b0;
        rst     = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
